saadi_accum: RTL
================

SAADI_ACCUM -- requirements
Module: saadi_accum

Interface
REQ-001 Parameter n, default 8, operand width; accumulator and term width is 2n.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request a new accumulation; sampled only in IDLE or DONE.
REQ-005 dividend  input  n  unsigned operand A, integer.
REQ-006 e  input  n  unsigned error fraction (value e/2^n); normalized divisor is 1-e.
REQ-007 t  input  n  log2 of the target iteration count.
REQ-008 acc_out  output  2n  accumulated quotient estimate; feeds the downstream right-shift stage.
REQ-009 counter  output  n  iteration count; the downstream stage consumes acc_out when counter equals 1<<t.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  high for exactly one cycle, in DONE.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 The effective exponent SHALL be te = min(t, n-1), and target = 1<<te (1..2^(n-1)).
REQ-014 The block SHALL capture dividend, e and te when start is sampled high in IDLE or DONE; it SHALL NOT re-sample these inputs until the next accepted start.
REQ-015 The load edge SHALL perform the following updates.
- term <= {A, n zeros}.
- acc_out <= {A, n zeros}.
- counter <= 1.
- Next state is DONE if target==1, else RUN.
REQ-016 Each RUN edge SHALL perform the following updates.
- term <= bits [3n-1:n] of the 3n-bit unsigned product term*e (truncation, no rounding).
- acc_out <= acc_out + new term, saturating at 2^(2n)-1.
- counter <= counter+1.
REQ-017 Once acc_out is saturated, it SHALL stay saturated until the next load.
REQ-018 In RUN, when the incremented counter equals target, the next state SHALL be DONE; iteration SHALL continue to target even if term reaches 0.
REQ-019 Exactly target-1 terms SHALL be added after the load term.
REQ-020 Latency: done SHALL be high in the cycle following the target-th rising edge, counting the edge that sampled start as edge 1.
REQ-021 DONE SHALL transition as follows.
- To RUN or DONE, per REQ-015, if start is high.
- Otherwise to IDLE.
REQ-022 In IDLE, acc_out and counter SHALL hold their final values, so counter==1<<t remains true for the downstream stage.
REQ-023 start SHALL be ignored while in RUN; in-flight operands SHALL be unaffected.
REQ-024 Changes on dividend, e or t during RUN SHALL have no effect.
REQ-025 The multiply SHALL be combinational within one cycle, giving one iteration per clock.

Reset
REQ-026 When rst is sampled high, the following SHALL occur.
- state <= IDLE.
- acc_out, counter and internal term <= 0.
- busy = 0 and done = 0.
REQ-027 Reset SHALL take priority over start and abort any RUN in progress with no done pulse.
REQ-028 In the first cycle after reset, start SHALL be accepted normally.

Verification
REQ-029 Scenario: A=0x80, e=0x80, t=2, start 1 cycle.
- acc_out after each edge: 0x8000, 0xC000, 0xE000, 0xF000.
- counter ends at 4.
- done high exactly 1 cycle, after edge 4.
- busy high for the 3 RUN cycles.
REQ-030 Scenario: A=0x55, t=0, any e.
- Next cycle: state DONE, acc_out=0x5500, counter=1, done=1, busy never high.
REQ-031 Scenario: A=0xFF, e=0xFF, t=7.
- After edge 2: acc_out=0xFFFF (0xFF00+0xFE01 saturates).
- acc_out stays 0xFFFF through counter=128.
- done is high in the cycle following edge 128.
REQ-032 Scenario: A=0x40, e=0x00, t=9.
- te clamps to 7.
- acc_out stays 0x4000.
- done is high in the cycle following edge 128.
REQ-033 Scenario: mid-RUN perturbation, A=0x80, e=0x80, t=3.
- After edge 3, pulse start and change A, e and t: result unchanged, final acc_out=0xFF00 with counter=8.
- On a second run, assert rst after edge 4: next cycle all outputs 0, IDLE, no done pulse.
REQ-034 Scenario: back-to-back operation.
- Assert start during the DONE cycle: the new operation loads with no IDLE gap.
- The previous result is still observable on acc_out and counter in the DONE cycle.

Source files
------------

// File: rtl/saadi_accum.sv
// saadi_accum: iterative quotient-estimate accumulator.
// Given a normalized divisor 1-e, it sums A * e^k for k = 0 .. target-1.
// That sum is the series expansion of A/(1-e), truncated to target terms.
// Each term is scaled by 2^n. A downstream stage consumes acc_out once
// counter reaches 1<<t.
module saadi_accum #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [n-1:0]   dividend,
  input  logic [n-1:0]   e,
  input  logic [n-1:0]   t,
  output logic [2*n-1:0] acc_out,
  output logic [n-1:0]   counter,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int TE_MAX = n - 1;

  state_t         state_reg, state_next;
  logic [2*n-1:0] term_reg, term_next;
  logic [2*n-1:0] acc_reg, acc_next;
  logic [n-1:0]   cnt_reg, cnt_next;
  logic [n-1:0]   e_reg, e_next;
  logic [n-1:0]   target_reg, target_next;

  // Datapath helpers
  logic [n-1:0]   te_w;
  logic [n-1:0]   target_w;
  logic [3*n-1:0] prod_w;
  logic [2*n-1:0] new_term_w;
  logic [2*n:0]   sum_w;
  logic [2*n-1:0] acc_sat_w;
  logic [n-1:0]   cnt_inc_w;
  logic [2*n-1:0] load_val_w;

  // The exponent is clamped so the target always fits in the n-bit counter.
  assign te_w       = (t > n'(TE_MAX)) ? n'(TE_MAX) : t;
  assign target_w   = n'(1) << te_w;
  assign load_val_w = {dividend, {n{1'b0}}};

  // The next term is term*e/2^n, truncated. It is computed at full 3n-bit width.
  assign prod_w     = {{n{1'b0}}, term_reg} * {{(2*n){1'b0}}, e_reg};
  assign new_term_w = (2*n)'(prod_w >> n);

  // A carry out of the adder clamps the sum to all ones. A saturated
  // accumulator therefore stays saturated: any non-zero term carries out again.
  assign sum_w      = {1'b0, acc_reg} + {1'b0, new_term_w};
  assign acc_sat_w  = sum_w[2*n] ? {(2*n){1'b1}} : sum_w[2*n-1:0];
  assign cnt_inc_w  = cnt_reg + n'(1);

  // State and datapath registers, with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      term_reg   <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      e_reg      <= '0;
      target_reg <= '0;
    end else begin
      state_reg  <= state_next;
      term_reg   <= term_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      e_reg      <= e_next;
      target_reg <= target_next;
    end
  end

  // Next-state and datapath selection. Operands are captured only on load,
  // so input changes while running have no effect.
  always_comb begin
    state_next  = state_reg;
    term_next   = term_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    e_next      = e_reg;
    target_next = target_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          term_next   = load_val_w;
          acc_next    = load_val_w;
          cnt_next    = n'(1);
          e_next      = e;
          target_next = target_w;
          state_next  = (target_w == n'(1)) ? DONE : RUN;
        end else if (state_reg == DONE) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        term_next = new_term_w;
        acc_next  = acc_sat_w;
        cnt_next  = cnt_inc_w;
        if (cnt_inc_w == target_reg) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign acc_out = acc_reg;
  assign counter = cnt_reg;
  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);

endmodule
